// File: rtl/data_control.sv
// Routes frames between the wenmiao, feikong, fakong and ADT serial links.
// Define DATACONTROL_ADT_TELEM_EN to build the ADT telemetry RAM writer.
module data_control #(
  parameter int POLL_PERIOD = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [455:0] wenmiao_rx_frame,
  input  logic         wenmiao_rx_frame_done,
  input  logic         wenmiao_check_sum_error,
  input  logic         wenmiao_comNoResponse,
  input  logic         wenmiao_tx_busy,
  input  logic [319:0] feikong_rx_frame,
  input  logic         feikong_rx_frame_done,
  input  logic         feikong_check_sum_error,
  input  logic         feikong_comNoResponse,
  input  logic         feikong_tx_busy,
  input  logic [71:0]  fakong_rx_frame,
  input  logic         fakong_rx_frame_done,
  input  logic         fakong_check_sum_error,
  input  logic         fakong_comNoResponse,
  input  logic         fakong_tx_busy,
  input  logic [199:0] adt_rx_frame,
  input  logic         adt_rx_frame_done,
  input  logic         adt_check_sum_error,
  input  logic         adt_comNoResponse,
  input  logic         adt_tx_busy,
  output logic [159:0] wenmiao_tx_frame,
  output logic         wenmiao_tx_start,
  output logic [79:0]  feikong_tx_frame,
  output logic         feikong_tx_frame_start,
  output logic [255:0] fakong_tx_frame,
  output logic         fakong_tx_start,
  output logic         adt_wr_ram,
  output logic [15:0]  adt_addr_ram,
  output logic [7:0]   adt_data_ram,
  output logic         adt_tx_frame_start
);
  localparam int CW = $clog2(POLL_PERIOD);

  logic [CW-1:0] cnt;
  logic          tick, snap;
  logic [7:0]    seq, s_now;
  logic          wm_ce, fk_ce, fa_ce, adt_ce;
  logic [455:0]  wm_rx;
  logic [319:0]  fk_rx;
  logic [71:0]   fa_rx;
  logic [199:0]  adt_rx;
  logic          wm_pend, fk_pend, fa_pend;

  function automatic logic [7:0] bsum(input logic [455:0] v);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 57; i++) s = s + v[8*i +: 8];
    return s;
  endfunction

  assign tick  = (cnt == CW'(POLL_PERIOD - 1));
  assign s_now = {wenmiao_comNoResponse, wm_ce, feikong_comNoResponse, fk_ce,
                  fakong_comNoResponse, fa_ce, adt_comNoResponse, adt_ce};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      seq  <= 8'd0;
      snap <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + 1'b1;
      seq  <= seq + {7'd0, tick};
      snap <= tick;
    end
  end

  // Error flags clear on the tick that reports them; a same-cycle error survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_ce <= 1'b0; fk_ce <= 1'b0; fa_ce <= 1'b0; adt_ce <= 1'b0;
    end else begin
      wm_ce  <= (wenmiao_rx_frame_done & wenmiao_check_sum_error) | (wm_ce & ~tick);
      fk_ce  <= (feikong_rx_frame_done & feikong_check_sum_error) | (fk_ce & ~tick);
      fa_ce  <= (fakong_rx_frame_done & fakong_check_sum_error) | (fa_ce & ~tick);
      adt_ce <= (adt_rx_frame_done & adt_check_sum_error) | (adt_ce & ~tick);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_rx <= '0; fk_rx <= '0; fa_rx <= '0; adt_rx <= '0;
    end else begin
      if (wenmiao_rx_frame_done && !wenmiao_check_sum_error) wm_rx <= wenmiao_rx_frame;
      if (feikong_rx_frame_done && !feikong_check_sum_error) fk_rx <= feikong_rx_frame;
      if (fakong_rx_frame_done && !fakong_check_sum_error)   fa_rx <= fakong_rx_frame;
      if (adt_rx_frame_done && !adt_check_sum_error)         adt_rx <= adt_rx_frame;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wenmiao_tx_frame <= '0;
      feikong_tx_frame <= '0;
      fakong_tx_frame  <= '0;
    end else if (tick) begin
      wenmiao_tx_frame <= {16'hEB90, 8'h01, seq, fk_rx[319:200],
                           8'h01 + seq + bsum(456'(fk_rx[319:200]))};
      feikong_tx_frame <= {16'hEB90, s_now, seq, fa_rx[71:32],
                           s_now + seq + bsum(456'(fa_rx[71:32]))};
      fakong_tx_frame  <= {16'hEB90, seq, s_now, fk_rx[319:104],
                           seq + s_now + bsum(456'(fk_rx[319:104]))};
    end
  end

  // Starts are held off during the snapshot cycle so a fresh frame is never sent twice.
  assign wenmiao_tx_start       = wm_pend & ~wenmiao_tx_busy & ~snap;
  assign feikong_tx_frame_start = fk_pend & ~feikong_tx_busy & ~snap;
  assign fakong_tx_start        = fa_pend & ~fakong_tx_busy & ~snap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_pend <= 1'b0; fk_pend <= 1'b0; fa_pend <= 1'b0;
    end else begin
      wm_pend <= snap | (wm_pend & ~wenmiao_tx_start);
      fk_pend <= snap | (fk_pend & ~feikong_tx_frame_start);
      fa_pend <= snap | (fa_pend & ~fakong_tx_start);
    end
  end

`ifdef DATACONTROL_ADT_TELEM_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} adt_st_t;
  adt_st_t      state, state_nxt;
  logic [495:0] pkt;
  logic [5:0]   waddr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (snap) state_nxt = S_WRITE;
      S_WRITE: if (waddr == 6'd61) state_nxt = S_WAIT;
      S_WAIT:  if (!adt_tx_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    adt_wr_ram         = (state == S_WRITE);
    adt_addr_ram       = (state == S_WRITE) ? {10'd0, waddr} : 16'd0;
    adt_data_ram       = (state == S_WRITE) ? pkt[495:488] : 8'd0;
    adt_tx_frame_start = (state == S_WAIT) && !adt_tx_busy;
  end

  // Packet is captured at the tick and shifted out MSB-first while writing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt   <= '0;
      waddr <= 6'd0;
    end else begin
      if (state == S_WRITE)
        pkt <= {pkt[487:0], 8'd0};
      else if (tick)
        pkt <= {16'hEB90, seq, s_now, wm_rx, seq + s_now + bsum(wm_rx)};
      waddr <= (state == S_WRITE) ? waddr + 6'd1 : 6'd0;
    end
  end
`else
  assign adt_wr_ram         = 1'b0;
  assign adt_addr_ram       = 16'd0;
  assign adt_data_ram       = 8'd0;
  assign adt_tx_frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_data_control.sv
// Directed-plus-random bench for data_control using a byte-level frame model.
module tb_data_control;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [455:0] wm_rxf = '0;
  logic [319:0] fk_rxf = '0;
  logic [71:0]  fa_rxf = '0;
  logic [199:0] adt_rxf = '0;
  logic [3:0]   done = '0, cerr = '0, nr = '0, busy = '0;

  logic [159:0] wenmiao_tx_frame;
  logic [79:0]  feikong_tx_frame;
  logic [255:0] fakong_tx_frame;
  logic         wenmiao_tx_start, feikong_tx_frame_start, fakong_tx_start;
  logic         adt_wr_ram, adt_tx_frame_start;
  logic [15:0]  adt_addr_ram;
  logic [7:0]   adt_data_ram;

  data_control #(.POLL_PERIOD(200)) dut (
    .clk(clk), .reset_n(reset_n),
    .wenmiao_rx_frame(wm_rxf), .wenmiao_rx_frame_done(done[0]),
    .wenmiao_check_sum_error(cerr[0]), .wenmiao_comNoResponse(nr[0]), .wenmiao_tx_busy(busy[0]),
    .feikong_rx_frame(fk_rxf), .feikong_rx_frame_done(done[1]),
    .feikong_check_sum_error(cerr[1]), .feikong_comNoResponse(nr[1]), .feikong_tx_busy(busy[1]),
    .fakong_rx_frame(fa_rxf), .fakong_rx_frame_done(done[2]),
    .fakong_check_sum_error(cerr[2]), .fakong_comNoResponse(nr[2]), .fakong_tx_busy(busy[2]),
    .adt_rx_frame(adt_rxf), .adt_rx_frame_done(done[3]),
    .adt_check_sum_error(cerr[3]), .adt_comNoResponse(nr[3]), .adt_tx_busy(busy[3]),
    .wenmiao_tx_frame(wenmiao_tx_frame), .wenmiao_tx_start(wenmiao_tx_start),
    .feikong_tx_frame(feikong_tx_frame), .feikong_tx_frame_start(feikong_tx_frame_start),
    .fakong_tx_frame(fakong_tx_frame), .fakong_tx_start(fakong_tx_start),
    .adt_wr_ram(adt_wr_ram), .adt_addr_ram(adt_addr_ram), .adt_data_ram(adt_data_ram),
    .adt_tx_frame_start(adt_tx_frame_start)
  );

  int cyc = 0;
  int errors = 0, checks = 0;

  // Output monitor: start pulses and RAM writes, sampled mid-cycle.
  logic [3:0] st;
  assign st = {adt_tx_frame_start, fakong_tx_start, feikong_tx_frame_start, wenmiao_tx_start};
  int st_cnt[4] = '{0, 0, 0, 0};
  int st_cyc[4] = '{-1, -1, -1, -1};
  int wr_cnt = 0, addr_bad = 0, wr_first = -1, run = 0, adt_nz = 0;
  logic prev_wr = 1'b0;
  logic [7:0] wbuf[64];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (st[i]) begin st_cnt[i]++; st_cyc[i] = cyc; end
    if (adt_wr_ram) begin
      if (!prev_wr) begin run = 0; wr_first = cyc; end
      if (adt_addr_ram != 16'(run)) addr_bad++;
      wbuf[adt_addr_ram[5:0]] = adt_data_ram;
      wr_cnt++;
      run++;
    end
    prev_wr = adt_wr_ram;
    if ({adt_wr_ram, adt_addr_ram, adt_data_ram, adt_tx_frame_start} != 26'd0) adt_nz++;
  end

  // Reference model: latest good frames as byte lists, sticky error flags, sequence.
  logic [7:0]   m_wm[57], m_fk[40], m_fa[9];
  bit           ce[4];
  int           seq_m;
  logic [511:0] e_wm, e_fk, e_fa, e_adt;
  int           b_st[4], b_wr, b_bad;

  function automatic logic [511:0] mk(input logic [7:0] q[$]);
    logic [511:0] r;
    logic [7:0]   cks;
    r = '0; cks = 8'd0;
    foreach (q[i]) begin
      if (i >= 2) cks = cks + q[i];
      r = {r[503:0], q[i]};
    end
    return {r[503:0], cks};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic bases();
    for (int i = 0; i < 4; i++) b_st[i] = st_cnt[i];
    b_wr = wr_cnt; b_bad = addr_bad;
  endtask

  task automatic model_reset();
    foreach (m_wm[i]) m_wm[i] = 8'd0;
    foreach (m_fk[i]) m_fk[i] = 8'd0;
    foreach (m_fa[i]) m_fa[i] = 8'd0;
    for (int i = 0; i < 4; i++) ce[i] = 1'b0;
    seq_m = 0;
  endtask

  task automatic snap();
    logic [7:0] s;
    logic [7:0] q[$];
    s = {nr[0], ce[0], nr[1], ce[1], nr[2], ce[2], nr[3], ce[3]};
    q = {8'hEB, 8'h90, 8'h01, 8'(seq_m)};
    for (int i = 0; i < 15; i++) q.push_back(m_fk[i]);
    e_wm = mk(q);
    q = {8'hEB, 8'h90, s, 8'(seq_m)};
    for (int i = 0; i < 5; i++) q.push_back(m_fa[i]);
    e_fk = mk(q);
    q = {8'hEB, 8'h90, 8'(seq_m), s};
    for (int i = 0; i < 27; i++) q.push_back(m_fk[i]);
    e_fa = mk(q);
    q = {8'hEB, 8'h90, 8'(seq_m), s};
    for (int i = 0; i < 57; i++) q.push_back(m_wm[i]);
    e_adt = mk(q);
    for (int i = 0; i < 4; i++) ce[i] = 1'b0;
    seq_m = (seq_m + 1) % 256;
    bases();
  endtask

  // One received frame on channel ch (0 wm, 1 fk, 2 fa, 3 adt); pat gives bytes 01,02,...
  task automatic rx(input int ch, input bit err, input bit pat);
    int n;
    logic [7:0]   b;
    logic [455:0] v;
    n = (ch == 0) ? 57 : (ch == 1) ? 40 : (ch == 2) ? 9 : 25;
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = pat ? 8'(i + 1) : 8'($urandom_range(0, 255));
      v = {v[447:0], b};
      if (!err) begin
        if (ch == 0) m_wm[i] = b;
        if (ch == 1) m_fk[i] = b;
        if (ch == 2) m_fa[i] = b;
      end
    end
    case (ch)
      0: wm_rxf = v;
      1: fk_rxf = v[319:0];
      2: fa_rxf = v[71:0];
      default: adt_rxf = v[199:0];
    endcase
    if (err) ce[ch] = 1'b1;
    done[ch] = 1'b1; cerr[ch] = err;
    go_to(cyc + 1);
    done = '0; cerr = '0;
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, "_wm"}, 512'(wenmiao_tx_frame), e_wm);
    chk({tag, "_fk"}, 512'(feikong_tx_frame), e_fk);
    chk({tag, "_fa"}, 512'(fakong_tx_frame), e_fa);
  endtask

  task automatic chk_st(input string tag, input int ch, input int ecyc);
    chk({tag, "_cnt"}, 512'(st_cnt[ch] - b_st[ch]), 512'(1));
    chk({tag, "_cyc"}, 512'(st_cyc[ch]), 512'(ecyc));
  endtask

  task automatic chk_adt(input string tag, input int t, input int scyc);
    logic [511:0] got;
`ifdef DATACONTROL_ADT_TELEM_EN
    got = '0;
    for (int i = 0; i < 62; i++) got = {got[503:0], wbuf[i]};
    chk({tag, "_wr_n"}, 512'(wr_cnt - b_wr), 512'(62));
    chk({tag, "_addr"}, 512'(addr_bad - b_bad), 512'(0));
    chk({tag, "_first"}, 512'(wr_first), 512'(t + 2));
    chk({tag, "_hdr"}, 512'({wbuf[0], wbuf[1]}), 512'(16'hEB90));
    chk({tag, "_pkt"}, got, e_adt);
    chk_st({tag, "_start"}, 3, scyc);
`else
    got = 512'(scyc);
    chk({tag, "_tied"}, 512'(adt_nz), 512'(0));
`endif
  endtask

  initial begin
    model_reset();
    busy[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wm", 512'(wenmiao_tx_frame), 512'(0));
    chk("rst_fk", 512'(feikong_tx_frame), 512'(0));
    chk("rst_fa", 512'(fakong_tx_frame), 512'(0));
    chk("rst_misc", 512'({st, adt_wr_ram, adt_addr_ram, adt_data_ram}), 512'(0));
    reset_n = 1'b1;
    cyc = 0;

    // Period 1: tick at 199, busy on wm/fa for 200..202, ADT busy until 269.
    go_to(50);  rx(1, 1'b0, 1'b1);
    go_to(60);  rx(0, 1'b0, 1'b0);
    go_to(70);  rx(2, 1'b0, 1'b0);
    go_to(198);
    chk("no_early_start", 512'(st_cnt[0] + st_cnt[1] + st_cnt[2]), 512'(0));
    go_to(199); snap();
    go_to(200);
    chk_frames("p1");
    chk("p1_hdr", 512'(wenmiao_tx_frame[159:128]), 512'(32'hEB900100));
    chk("p1_S", 512'(feikong_tx_frame[63:56]), 512'(0));
    busy[0] = 1'b1; busy[2] = 1'b1;
    go_to(203); busy[0] = 1'b0; busy[2] = 1'b0;
    go_to(209);
    chk_st("p1_wm", 0, 203); chk_st("p1_fk", 1, 201); chk_st("p1_fa", 2, 203);
    go_to(269); busy[3] = 1'b0;
    go_to(275); chk_adt("p1_adt", 199, 269);

    // Period 2: rejected fa/adt frames, wm silent across the tick.
    go_to(250); rx(2, 1'b1, 1'b0);
    go_to(255); rx(3, 1'b1, 1'b0);
    go_to(260); nr[0] = 1'b1;
    go_to(300); rx(1, 1'b0, 1'b0);
    go_to(320); rx(0, 1'b0, 1'b0);
    go_to(399); snap();
    go_to(400);
    chk_frames("p2");
    chk("p2_S", 512'(feikong_tx_frame[63:56]), 512'(8'h85));
    nr[0] = 1'b0;
    go_to(406);
    chk_st("p2_wm", 0, 401); chk_st("p2_fk", 1, 401); chk_st("p2_fa", 2, 401);
    go_to(470); chk_adt("p2_adt", 399, 463);

    // Period 3: error flags cleared; a fa error lands on the tick cycle itself.
    go_to(599); snap(); rx(2, 1'b1, 1'b0);
    chk_frames("p3");
    chk("p3_S", 512'(feikong_tx_frame[63:56]), 512'(0));
    go_to(606); chk_st("p3_fk", 1, 601);
    go_to(670); chk_adt("p3_adt", 599, 663);

    // Period 4: same-cycle error survived the clear; then reset during RAM writes.
    go_to(799); snap();
    go_to(800);
    chk_frames("p4");
    chk("p4_S", 512'(feikong_tx_frame[63:56]), 512'(8'h04));
    go_to(810);
`ifdef DATACONTROL_ADT_TELEM_EN
    chk("mid_wr_active", 512'(adt_wr_ram), 512'(1));
`else
    chk("mid_wr_active", 512'(adt_wr_ram), 512'(0));
`endif
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", 512'({adt_wr_ram, adt_addr_ram, adt_data_ram}), 512'(0));
    chk("mid_rst_frames", 512'({wenmiao_tx_frame, feikong_tx_frame}), 512'(0));
    model_reset();
    go_to(811); reset_n = 1'b1; bases();
    go_to(1009);
    chk("post_rst_writes", 512'(wr_cnt - b_wr), 512'(0));
    chk("post_rst_starts", 512'({st_cnt[0] - b_st[0], st_cnt[1] - b_st[1],
                                  st_cnt[2] - b_st[2], st_cnt[3] - b_st[3]}), 512'(0));
    go_to(1010); snap();
    go_to(1011);
    chk_frames("p5");
    chk("p5_hdr", 512'(wenmiao_tx_frame[159:128]), 512'(32'hEB900100));
`ifndef DATACONTROL_ADT_TELEM_EN
    chk("adt_tied_all", 512'(adt_nz), 512'(0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
